// File: rtl/dmem_latency_ctrl_pkg.sv
// Shared control types for the data-memory path: access size/sign encodings
// (funct3-style) and small decode helpers.
package dmem_latency_ctrl_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_op_t;

    function automatic logic op_is_byte(input mem_op_t op);
        return (op == MEM_B) || (op == MEM_BU);
    endfunction

    function automatic logic op_is_half(input mem_op_t op);
        return (op == MEM_H) || (op == MEM_HU);
    endfunction

endpackage

// File: rtl/dmem_latency_ctrl_array.sv
// Word-indexed data storage with per-byte write enables and combinational read.
module dmem_array #(
    parameter  int DEPTH_WORDS = 1024,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_latency_ctrl.sv
// Fixed-latency data-memory controller: accepts one load/store, waits LATENCY
// edges, then presents a single-cycle response with alignment/range fault.
module dmem_latency_ctrl
    import dmem_latency_ctrl_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  mem_op_t     req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;

    logic        wr_p0;
    mem_op_t     op_p0;
    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;

    logic        accept;
    logic        enter_resp;
    logic        acc_wr;
    mem_op_t     acc_op;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_fault;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    function automatic logic access_fault(input mem_op_t op, input logic [31:0] addr);
        logic misaligned;
        if (op_is_byte(op))      misaligned = 1'b0;
        else if (op_is_half(op)) misaligned = addr[0];
        else                     misaligned = (addr[1:0] != 2'b00);
        return misaligned || ({1'b0, addr} >= ADDR_LIMIT);
    endfunction

    function automatic logic [3:0] store_be(input mem_op_t op, input logic [1:0] off);
        if (op_is_byte(op))      return 4'b0001 << off;
        else if (op_is_half(op)) return 4'b0011 << off;
        else                     return 4'b1111;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input mem_op_t op,
                                                input logic [1:0] off);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (op)
            MEM_B:   return {{24{sh[7]}}, sh[7:0]};
            MEM_BU:  return {24'h0, sh[7:0]};
            MEM_H:   return {{16{sh[15]}}, sh[15:0]};
            MEM_HU:  return {16'h0, sh[15:0]};
            default: return word;
        endcase
    endfunction

    assign accept = req_valid && req_ready;

    // With LATENCY=1 the response is produced on the acceptance edge itself,
    // so the live request fields feed the datapath while still in IDLE.
    always_comb begin
        acc_wr    = wr_p0;
        acc_op    = op_p0;
        acc_addr  = addr_p0;
        acc_wdata = wdata_p0;
        if (state == IDLE) begin
            acc_wr    = req_wr;
            acc_op    = req_op;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end
    end

    assign enter_resp = ((state == IDLE) && accept && (LATENCY == 1)) ||
                        ((state == WAIT) && (cnt == 4'(LATENCY - 2)));
    assign acc_fault  = access_fault(acc_op, acc_addr);
    assign mem_we     = (enter_resp && acc_wr && !acc_fault) ? store_be(acc_op, acc_addr[1:0]) : 4'b0000;
    assign mem_wdata  = acc_wdata << {acc_addr[1:0], 3'b000};

    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (acc_addr[AW+1:2]),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // Stage p0: request capture (data only, no reset)
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_p0    <= req_wr;
            op_p0    <= req_op;
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        cnt       <= '0;
                        state     <= (LATENCY > 1) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    if (cnt == 4'(LATENCY - 2)) state <= RESP;
                    else                        cnt   <= cnt + 4'd1;
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_fault <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
            if (enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_fault <= acc_fault;
                rsp_rdata <= (acc_fault || acc_wr) ? 32'h0 : load_extend(mem_rdata, acc_op, acc_addr[1:0]);
            end
        end
    end

endmodule

// File: tb/tb_dmem_latency_ctrl.sv
// Directed bench: three controllers at LATENCY 2, 4 and 1 sharing one clock.
module tb_dmem_latency_ctrl;
    import dmem_latency_ctrl_pkg::*;

    localparam int NDUT  = 3;
    localparam int DEPTH = 1024;

    typedef struct packed {
        logic        wr;
        mem_op_t     op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        flt;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn    [NDUT];
    logic        req_valid [NDUT];
    logic        req_ready [NDUT];
    logic        req_wr    [NDUT];
    mem_op_t     req_op    [NDUT];
    logic [31:0] req_addr  [NDUT];
    logic [31:0] req_wdata [NDUT];
    logic        rsp_valid [NDUT];
    logic [31:0] rsp_rdata [NDUT];
    logic        rsp_fault [NDUT];

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] rd;
    logic        ft;
    int          lat;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 4 : 1);
        dmem_latency_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
            .clk       (clk),
            .resetn    (resetn[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_wr    (req_wr[g]),
            .req_op    (req_op[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_fault (rsp_fault[g])
        );
    end

    // Issue one request from a negedge; returns data, fault and the number of
    // negedges from acceptance until rsp_valid is seen (-1 if never).
    task automatic do_req(input int d, input logic wr, input mem_op_t op, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata, output logic fault,
                          output int nlat);
        int waited = 0;
        rdata = '0; fault = 1'b0; nlat = -1;
        req_wr[d] = wr; req_op[d] = op; req_addr[d] = addr; req_wdata[d] = wdata;
        req_valid[d] = 1'b1;
        while (!req_ready[d] && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready[d]) begin
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (rsp_valid[d]) begin
                nlat = n; rdata = rsp_rdata[d]; fault = rsp_fault[d];
                break;
            end
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < NDUT; d++) begin
            resetn[d] = 1'b0; req_valid[d] = 1'b0; req_wr[d] = 1'b0; req_op[d] = MEM_W;
            req_addr[d] = '0; req_wdata[d] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            compared++;
            if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'h0 || rsp_fault[d] !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_state dut%0d: ready=%b valid=%b rdata=%h fault=%b, want 1 0 00000000 0",
                         d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_fault[d]);
            end
        end
        for (int d = 0; d < NDUT; d++) resetn[d] = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word();
        do_req(0, 1'b1, MEM_W, 32'h100, 32'h12345678, rd, ft, lat);
        compared++;
        if (lat !== 2 || rd !== 32'h0 || ft !== 1'b0) begin
            mismatched++;
            $display("FAIL sw_0x100: lat=%0d rdata=%h fault=%b, want lat=2 rdata=00000000 fault=0", lat, rd, ft);
        end
        do_req(0, 1'b0, MEM_W, 32'h100, 32'h0, rd, ft, lat);
        compared++;
        if (lat !== 2 || rd !== 32'h12345678 || ft !== 1'b0) begin
            mismatched++;
            $display("FAIL lw_0x100: lat=%0d rdata=%h fault=%b, want lat=2 rdata=12345678 fault=0", lat, rd, ft);
        end
    endtask

    task automatic test_subword();
        vec_t tbl [13];
        tbl[0]  = '{1'b0, MEM_BU, 32'h101, 32'h0,        32'h00000056, 1'b0};
        tbl[1]  = '{1'b0, MEM_HU, 32'h102, 32'h0,        32'h00001234, 1'b0};
        tbl[2]  = '{1'b0, MEM_H,  32'h102, 32'h0,        32'h00001234, 1'b0};
        tbl[3]  = '{1'b0, MEM_B,  32'h103, 32'h0,        32'h00000012, 1'b0};
        tbl[4]  = '{1'b1, MEM_B,  32'h100, 32'hFFFFFFAA, 32'h00000000, 1'b0};
        tbl[5]  = '{1'b0, MEM_W,  32'h100, 32'h0,        32'h123456AA, 1'b0};
        tbl[6]  = '{1'b1, MEM_B,  32'h104, 32'h12345680, 32'h00000000, 1'b0};
        tbl[7]  = '{1'b0, MEM_B,  32'h104, 32'h0,        32'hFFFFFF80, 1'b0};
        tbl[8]  = '{1'b0, MEM_BU, 32'h104, 32'h0,        32'h00000080, 1'b0};
        tbl[9]  = '{1'b1, MEM_H,  32'h106, 32'h7777BEEF, 32'h00000000, 1'b0};
        tbl[10] = '{1'b0, MEM_H,  32'h106, 32'h0,        32'hFFFFBEEF, 1'b0};
        tbl[11] = '{1'b0, MEM_HU, 32'h106, 32'h0,        32'h0000BEEF, 1'b0};
        tbl[12] = '{1'b0, MEM_BU, 32'h107, 32'h0,        32'h000000BE, 1'b0};
        for (int i = 0; i < 13; i++) begin
            do_req(0, tbl[i].wr, tbl[i].op, tbl[i].addr, tbl[i].wdata, rd, ft, lat);
            compared++;
            if (lat !== 2 || rd !== tbl[i].exp || ft !== tbl[i].flt) begin
                mismatched++;
                $display("FAIL subword[%0d] addr=%h: lat=%0d rdata=%h fault=%b, want lat=2 rdata=%h fault=%b",
                         i, tbl[i].addr, lat, rd, ft, tbl[i].exp, tbl[i].flt);
            end
        end
    endtask

    task automatic test_fault();
        vec_t tbl [9];
        tbl[0] = '{1'b1, MEM_W,  32'h000,  32'hCAFEF00D, 32'h00000000, 1'b0};
        tbl[1] = '{1'b1, MEM_W,  32'h1000, 32'hDEADBEEF, 32'h00000000, 1'b1};
        tbl[2] = '{1'b0, MEM_W,  32'h000,  32'h0,        32'hCAFEF00D, 1'b0};
        tbl[3] = '{1'b0, MEM_W,  32'h102,  32'h0,        32'h00000000, 1'b1};
        tbl[4] = '{1'b0, MEM_H,  32'h101,  32'h0,        32'h00000000, 1'b1};
        tbl[5] = '{1'b1, MEM_W,  32'h102,  32'hFFFFFFFF, 32'h00000000, 1'b1};
        tbl[6] = '{1'b1, MEM_H,  32'h103,  32'hFFFFFFFF, 32'h00000000, 1'b1};
        tbl[7] = '{1'b0, MEM_W,  32'h100,  32'h0,        32'h123456AA, 1'b0};
        tbl[8] = '{1'b0, MEM_BU, 32'h1001, 32'h0,        32'h00000000, 1'b1};
        for (int i = 0; i < 9; i++) begin
            do_req(0, tbl[i].wr, tbl[i].op, tbl[i].addr, tbl[i].wdata, rd, ft, lat);
            compared++;
            if (lat !== 2 || rd !== tbl[i].exp || ft !== tbl[i].flt) begin
                mismatched++;
                $display("FAIL fault[%0d] addr=%h: lat=%0d rdata=%h fault=%b, want lat=2 rdata=%h fault=%b",
                         i, tbl[i].addr, lat, rd, ft, tbl[i].exp, tbl[i].flt);
            end
        end
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        do_req(1, 1'b1, MEM_W, 32'h20, 32'h11112222, rd, ft, lat);
        compared++;
        if (lat !== 4 || rd !== 32'h0 || ft !== 1'b0) begin
            mismatched++;
            $display("FAIL lat4_sw: lat=%0d rdata=%h fault=%b, want lat=4 rdata=00000000 fault=0", lat, rd, ft);
        end
        do_req(1, 1'b0, MEM_W, 32'h20, 32'h0, rd, ft, lat);
        compared++;
        if (lat !== 4 || rd !== 32'h11112222) begin
            mismatched++;
            $display("FAIL lat4_lw: lat=%0d rdata=%h, want lat=4 rdata=11112222", lat, rd);
        end
        @(negedge clk);
        req_wr[1] = 1'b1; req_op[1] = MEM_W; req_addr[1] = 32'h20; req_wdata[1] = 32'h99999999;
        req_valid[1] = 1'b1;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        resetn[1] = 1'b0;
        #1;
        compared++;
        if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_async: ready=%b valid=%b, want 1 0", req_ready[1], rsp_valid[1]);
        end
        @(negedge clk);
        resetn[1] = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (rsp_valid[1]) seen++;
        end
        compared++;
        if (seen !== 0 || req_ready[1] !== 1'b1) begin
            mismatched++;
            $display("FAIL abort_no_rsp: rsp cycles=%0d ready=%b, want 0 1", seen, req_ready[1]);
        end
        do_req(1, 1'b0, MEM_W, 32'h20, 32'h0, rd, ft, lat);
        compared++;
        if (lat !== 4 || rd !== 32'h11112222 || ft !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_readback: lat=%0d rdata=%h fault=%b, want lat=4 rdata=11112222 fault=0", lat, rd, ft);
        end
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        logic exp_rdy;
        do_req(2, 1'b1, MEM_W, 32'h40, 32'hA5A50001, rd, ft, lat);
        compared++;
        if (lat !== 1 || ft !== 1'b0) begin
            mismatched++;
            $display("FAIL lat1_sw: lat=%0d fault=%b, want lat=1 fault=0", lat, ft);
        end
        @(negedge clk);
        req_wr[2] = 1'b0; req_op[2] = MEM_W; req_addr[2] = 32'h40; req_valid[2] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_rdy = ((i % 2) == 0);
            compared++;
            if (req_ready[2] !== exp_rdy || rsp_valid[2] !== !exp_rdy ||
                rsp_rdata[2] !== (exp_rdy ? 32'h0 : 32'hA5A50001)) begin
                mismatched++;
                $display("FAIL b2b_cycle%0d: ready=%b valid=%b rdata=%h, want %b %b %h", i, req_ready[2],
                         rsp_valid[2], rsp_rdata[2], exp_rdy, !exp_rdy, exp_rdy ? 32'h0 : 32'hA5A50001);
            end
            if (req_ready[2] && req_valid[2]) accepts++;
            @(negedge clk);
        end
        req_valid[2] = 1'b0;
        compared++;
        if (accepts !== 4) begin
            mismatched++;
            $display("FAIL b2b_accepts: got %0d, want 4", accepts);
        end
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_fault();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
